// File: rtl/is_uart_pkg.sv
// Shared types and helpers for the UART receive path.
package is_uart_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic int clks_per_bit(input int clk, input int baud);
      return clk / baud;
   endfunction

   // Expected parity bit for the (zero-extended) data word.
   function automatic logic parity_calc(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/is_uart_baud_cnt.sv
// Mid-bit tick generator: first tick HALF cycles after restart, then one every CLKS_PER_BIT.
module is_uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic mid_tick_o
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          first_q, first_d;

   // The restart cycle is cycle 0, so the count lags the cycle index by one.
   assign mid_tick_o = first_q ? (cnt_q == CW'(HALF - 1)) : (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      first_d = first_q;
      if (restart_i) begin
         cnt_d   = '0;
         first_d = 1'b1;
      end else if (mid_tick_o) begin
         cnt_d   = '0;
         first_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         first_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/is_uart_rx.sv
// UART receive deframer: start detect, mid-bit sampling, optional parity, stop check,
// and a valid/ready output register with framing, parity and overrun flags.
module is_uart_rx
   import is_uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 uart_rxd_r_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_param_check
      $fatal(1, "is_uart_rx: CLKS_PER_BIT must be >= 4 and DATA_BITS within 5..9");
   end

   rx_state_t            state_q, state_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 restart;
   logic                 mid_tick;
   logic [8:0]           shift_ext;

   is_uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (restart),
      .mid_tick_o(mid_tick)
   );

   assign shift_ext = 9'(shift_q);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_bit_d = par_bit_q;
      data_d    = data_q;
      valid_d   = valid_q & ~ready_i;
      perr_d    = perr_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      restart   = 1'b0;

      case (state_q)
         WAIT_IDLE: begin
            if (uart_rxd_r_i) state_d = IDLE;
         end
         IDLE: begin
            if (!uart_rxd_r_i) begin
               state_d = START;
               restart = 1'b1;
            end
         end
         START: begin
            if (mid_tick) begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (uart_rxd_r_i) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (mid_tick) begin
               shift_d = {uart_rxd_r_i, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (mid_tick) begin
               par_bit_d = uart_rxd_r_i;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (mid_tick) begin
               if (uart_rxd_r_i) begin
                  state_d = IDLE;
                  // An unaccepted word is kept; the new one is dropped and flagged.
                  if (!valid_q || ready_i) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     perr_d  = (PARITY_EN != 0) &&
                               (parity_calc(shift_ext, (PARITY_ODD != 0)) != par_bit_q);
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= WAIT_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_bit_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_bit_q <= par_bit_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;
   // WAIT_IDLE is a post-reset/post-error hold, not an active frame.
   assign busy_o       = (state_q != IDLE) && (state_q != WAIT_IDLE);

endmodule
